fadd_arbiter: RTL and testbench
===============================

FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 16, max operations issued to the adder and not yet returned (power of 2, 2..64).
REQ-002 SHALL have ports `clk` and `rstn`, each input, width 1: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports Rn_A_TDATA and Rn_B_TDATA (n=0,1), input, width 32: requester n operand pair.
REQ-004 SHALL have ports Rn_TLAST and Rn_TVALID, input, width 1: requester n packet end and request valid.
REQ-005 SHALL have port Rn_TREADY, output, width 1: requester n operand pair accepted.
REQ-006 SHALL have ports Rn_OUT_TDATA (width 32), Rn_OUT_TLAST and Rn_OUT_TVALID (width 1), output: sum returned to requester n (no ready).
REQ-007 SHALL have ports FA_A_TDATA and FA_B_TDATA, output, width 32: operands driven to the shared fadd.
REQ-008 SHALL have ports FA_A_TLAST, FA_A_TVALID, FA_B_TLAST and FA_B_TVALID, output, width 1: adder channel control.
REQ-009 SHALL have ports FA_A_TREADY and FA_B_TREADY, input, width 1: adder channel ready.
REQ-010 SHALL have ports FA_OUT_TDATA (width 32) and FA_OUT_TVALID (width 1), input: adder result (no ready).
REQ-011 SHALL have port BUSY, output, width 1: state != IDLE or in-flight count != 0.
REQ-012 SHALL have port ERR, output, width 1: sticky; set on a result with no tag outstanding.

Function
REQ-013 SHALL use FSM states IDLE and ISSUE.
REQ-014 SHALL, in IDLE with inflight < MAX_INFLIGHT, grant round-robin among valid requesters: sole valid requester wins; if both are valid, the requester not granted last wins; last-grant pointer resets to R1 so R0 wins first.
REQ-015 SHALL drive Rn_TREADY high combinationally only for the granted requester in IDLE with credit available; it SHALL be 0 otherwise.
REQ-016 SHALL, on acceptance: capture A/B/TLAST into the issue register, push tag {n, TLAST} into the tag FIFO, increment inflight, and go to ISSUE.
REQ-017 SHALL, in ISSUE, drive FA_A_TVALID and FA_B_TVALID high starting the cycle after acceptance, with FA_A_TLAST = FA_B_TLAST = captured TLAST.
REQ-018 SHALL track each channel independently: a channel's TVALID drops the cycle after its handshake and stays 0 while the other channel is pending; data stays stable until handshake.
REQ-019 SHALL go from ISSUE to IDLE the cycle after both channels have completed; the same-cycle case is handled identically; sustained rate is 1 op per 2 cycles.
REQ-020 SHALL, on FA_OUT_TVALID with tag FIFO non-empty, pop the tag and register the result: Rn_OUT_TDATA = FA_OUT_TDATA, Rn_OUT_TLAST = tag TLAST, and Rn_OUT_TVALID high for exactly 1 cycle (latency 1), for the tagged n only.
REQ-021 SHALL treat FA_OUT_TVALID with the FIFO empty as an underflow: set ERR, produce no output, leave count unchanged.
REQ-022 SHALL keep inflight unchanged when push and pop occur in the same cycle.
REQ-023 SHALL return results in issue order; inflight ranges 0..MAX_INFLIGHT and never wraps.
REQ-024 SHALL drive Rn_OUT_TDATA held at its last value when Rn_OUT_TVALID is 0.

Reset
REQ-025 SHALL, on rstn low (asynchronous), force: state IDLE, all TVALID/TREADY/OUT_TVALID 0, data registers 0, inflight 0, FIFO empty, ERR 0, pointer R1.
REQ-026 SHALL discard an in-progress ISSUE or any outstanding tag at reset; results arriving after reset hit the underflow rule (REQ-021).

Structure
REQ-027 SHALL place FSM enum, tag struct {req_id, last}, FP_W=32 and the default MAX_INFLIGHT in shared package fadd_pkg.
REQ-028 SHALL implement the tag FIFO as sub-module tag_fifo (synchronous, depth MAX_INFLIGHT, push/pop/full/empty, simultaneous push+pop legal).

Verification
REQ-029 SHALL cover: R0 sends 0x3F800000 + 0x40000000 -> FA_A/FA_B show these the next cycle; model returns 0x40400000 -> R0_OUT_TDATA = 0x40400000 for 1 cycle, R1_OUT_TVALID stays 0.
REQ-030 SHALL cover: R0 and R1 both valid for 8 ops -> grants R0,R1,R0,...; each requester receives its 4 sums in order, with TLAST on the packet-final op only.
REQ-031 SHALL cover: FA_B_TREADY low 3 cycles with FA_A_TREADY high -> exactly one A handshake, A_TVALID drops, B held stable, IDLE returned after the B handshake, no duplicate.
REQ-032 SHALL cover: MAX_INFLIGHT=4 with results withheld -> 4 accepted; Rn_TREADY low until the first result returns, then 5th accepted.
REQ-033 SHALL cover: FA_OUT_TVALID pulse with nothing outstanding -> ERR = 1 and stays 1; no Rn_OUT_TVALID.
REQ-034 SHALL cover: rstn low during ISSUE -> FA_*_TVALID = 0 immediately, BUSY = 0, next grant goes to R0.

Source files
------------

// File: rtl/fadd_pkg.sv
// Shared types and constants for the floating-point adder arbiter.
package fadd_pkg;

    localparam int FP_W                 = 32;
    localparam int DEFAULT_MAX_INFLIGHT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic req_id;
        logic last;
    } tag_t;

endpackage

// File: rtl/fadd_arbiter_tag_fifo.sv
// Tag FIFO remembering which requester owns each operation still inside the adder.
module tag_fifo
    import fadd_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_INFLIGHT
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_push,
    input  tag_t i_data,
    input  logic i_pop,
    output tag_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    tag_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Two-requester round-robin front end sharing one AXI-stream floating-point adder,
// with tagged in-order routing of results back to their requester.
module fadd_arbiter
    import fadd_pkg::*;
#(
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [FP_W-1:0] R0_A_TDATA,
    input  logic [FP_W-1:0] R0_B_TDATA,
    input  logic            R0_TLAST,
    input  logic            R0_TVALID,
    output logic            R0_TREADY,
    output logic [FP_W-1:0] R0_OUT_TDATA,
    output logic            R0_OUT_TLAST,
    output logic            R0_OUT_TVALID,
    input  logic [FP_W-1:0] R1_A_TDATA,
    input  logic [FP_W-1:0] R1_B_TDATA,
    input  logic            R1_TLAST,
    input  logic            R1_TVALID,
    output logic            R1_TREADY,
    output logic [FP_W-1:0] R1_OUT_TDATA,
    output logic            R1_OUT_TLAST,
    output logic            R1_OUT_TVALID,
    output logic [FP_W-1:0] FA_A_TDATA,
    output logic [FP_W-1:0] FA_B_TDATA,
    output logic            FA_A_TLAST,
    output logic            FA_A_TVALID,
    output logic            FA_B_TLAST,
    output logic            FA_B_TVALID,
    input  logic            FA_A_TREADY,
    input  logic            FA_B_TREADY,
    input  logic [FP_W-1:0] FA_OUT_TDATA,
    input  logic            FA_OUT_TVALID,
    output logic            BUSY,
    output logic            ERR
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    state_t          r_state;
    logic            r_last_grant;
    logic [CW-1:0]   r_inflight;
    logic [FP_W-1:0] r_a;
    logic [FP_W-1:0] r_b;
    logic            r_last;
    logic            r_a_valid;
    logic            r_b_valid;
    logic [FP_W-1:0] r_out_data [2];
    logic [1:0]      r_out_last;
    logic [1:0]      r_out_valid;
    logic            r_err;

    logic            w_credit;
    logic            w_grant_valid;
    logic            w_grant_id;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_a_done;
    logic            w_b_done;
    tag_t            w_tag_in;
    tag_t            w_tag_out;

    // Grant only in IDLE with credit; rstn gating keeps TREADY low throughout reset.
    assign w_credit      = (r_inflight < CW'(MAX_INFLIGHT)) && !w_full;
    assign w_grant_id    = (R0_TVALID && R1_TVALID) ? ~r_last_grant : R1_TVALID;
    assign w_grant_valid = rstn && (r_state == IDLE) && w_credit && (R0_TVALID || R1_TVALID);
    assign R0_TREADY     = w_grant_valid && !w_grant_id;
    assign R1_TREADY     = w_grant_valid && w_grant_id;

    assign w_push          = w_grant_valid;
    assign w_pop           = FA_OUT_TVALID && !w_empty;
    assign w_tag_in.req_id = w_grant_id;
    assign w_tag_in.last   = w_grant_id ? R1_TLAST : R0_TLAST;
    assign w_a_done        = !r_a_valid || FA_A_TREADY;
    assign w_b_done        = !r_b_valid || FA_B_TREADY;

    assign FA_A_TDATA  = r_a;
    assign FA_B_TDATA  = r_b;
    assign FA_A_TLAST  = r_last;
    assign FA_B_TLAST  = r_last;
    assign FA_A_TVALID = r_a_valid;
    assign FA_B_TVALID = r_b_valid;

    assign R0_OUT_TDATA  = r_out_data[0];
    assign R1_OUT_TDATA  = r_out_data[1];
    assign R0_OUT_TLAST  = r_out_last[0];
    assign R1_OUT_TLAST  = r_out_last[1];
    assign R0_OUT_TVALID = r_out_valid[0];
    assign R1_OUT_TVALID = r_out_valid[1];
    assign BUSY          = (r_state != IDLE) || (r_inflight != '0);
    assign ERR           = r_err;

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_tag_in),
        .i_pop   (w_pop),
        .o_data  (w_tag_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Each adder channel retires independently; ISSUE ends once both have handshaked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_last       <= 1'b0;
            r_a_valid    <= 1'b0;
            r_b_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_a          <= w_grant_id ? R1_A_TDATA : R0_A_TDATA;
                        r_b          <= w_grant_id ? R1_B_TDATA : R0_B_TDATA;
                        r_last       <= w_tag_in.last;
                        r_a_valid    <= 1'b1;
                        r_b_valid    <= 1'b1;
                        r_last_grant <= w_grant_id;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (FA_A_TREADY) begin
                        r_a_valid <= 1'b0;
                    end
                    if (FA_B_TREADY) begin
                        r_b_valid <= 1'b0;
                    end
                    if (w_a_done && w_b_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // A result with no outstanding tag is dropped and latches ERR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_data[0] <= '0;
            r_out_data[1] <= '0;
            r_out_last    <= '0;
            r_out_valid   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_out_valid <= '0;
            if (w_pop) begin
                r_out_valid[w_tag_out.req_id] <= 1'b1;
                r_out_data[w_tag_out.req_id]  <= FA_OUT_TDATA;
                r_out_last[w_tag_out.req_id]  <= w_tag_out.last;
            end
            if (FA_OUT_TVALID && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench: cycle-level transaction model plus directed scenarios for fadd_arbiter.
module tb_fadd_arbiter;
    import fadd_pkg::*;

    localparam int MAXI = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] R0_A_TDATA, R0_B_TDATA, R1_A_TDATA, R1_B_TDATA;
    logic        R0_TLAST, R0_TVALID, R0_TREADY, R1_TLAST, R1_TVALID, R1_TREADY;
    logic [31:0] R0_OUT_TDATA, R1_OUT_TDATA;
    logic        R0_OUT_TLAST, R0_OUT_TVALID, R1_OUT_TLAST, R1_OUT_TVALID;
    logic [31:0] FA_A_TDATA, FA_B_TDATA, FA_OUT_TDATA;
    logic        FA_A_TLAST, FA_A_TVALID, FA_B_TLAST, FA_B_TVALID;
    logic        FA_A_TREADY, FA_B_TREADY, FA_OUT_TVALID;
    logic        BUSY, ERR;

    typedef struct packed { logic [31:0] a; logic [31:0] b; logic last; } op_t;
    typedef struct packed { logic [31:0] d; int due; } sum_t;
    typedef struct packed { logic id; logic last; } mtag_t;

    int          assertions = 0;
    int          failures = 0;
    int          cyc = 0;
    op_t         reqQ0[$], reqQ1[$];
    logic [31:0] manualQ[$], aQ[$], bQ[$];
    sum_t        sumQ[$];
    bit          autoEn = 1'b0;
    int          grantLog[$];
    int          aHs = 0, bHs = 0, outCnt0 = 0, outCnt1 = 0;
    logic [31:0] rx0[$], rx1[$], exp0[$], exp1[$];
    logic        rxL0[$], rxL1[$], expL0[$], expL1[$];
    bit          h0, h1;

    bit          mPend, mALeft, mBLeft, mL, mLastGrant, mErr;
    logic [31:0] mA, mB;
    mtag_t       mTags[$];
    logic [31:0] mOutD[2];
    logic        mOutL[2];
    bit          mOutV[2];

    fadd_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rstn(rstn),
        .R0_A_TDATA(R0_A_TDATA), .R0_B_TDATA(R0_B_TDATA), .R0_TLAST(R0_TLAST),
        .R0_TVALID(R0_TVALID), .R0_TREADY(R0_TREADY), .R0_OUT_TDATA(R0_OUT_TDATA),
        .R0_OUT_TLAST(R0_OUT_TLAST), .R0_OUT_TVALID(R0_OUT_TVALID),
        .R1_A_TDATA(R1_A_TDATA), .R1_B_TDATA(R1_B_TDATA), .R1_TLAST(R1_TLAST),
        .R1_TVALID(R1_TVALID), .R1_TREADY(R1_TREADY), .R1_OUT_TDATA(R1_OUT_TDATA),
        .R1_OUT_TLAST(R1_OUT_TLAST), .R1_OUT_TVALID(R1_OUT_TVALID),
        .FA_A_TDATA(FA_A_TDATA), .FA_B_TDATA(FA_B_TDATA), .FA_A_TLAST(FA_A_TLAST),
        .FA_A_TVALID(FA_A_TVALID), .FA_B_TLAST(FA_B_TLAST), .FA_B_TVALID(FA_B_TVALID),
        .FA_A_TREADY(FA_A_TREADY), .FA_B_TREADY(FA_B_TREADY),
        .FA_OUT_TDATA(FA_OUT_TDATA), .FA_OUT_TVALID(FA_OUT_TVALID),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Small-integer float helpers: the bench plays the adder with exact integer sums.
    function automatic logic [31:0] int2f(input int n);
        int e;
        e = 0;
        for (int i = 0; i < 24; i++) if (n >= (1 << i)) e = i;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic int f2int(input logic [31:0] f);
        int e;
        e = int'(f[30:23]) - 127;
        return int'({8'd0, 1'b1, f[22:0]}) >> (23 - e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'd0, actual}, {31'd0, expected});
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] a, input logic [31:0] b, input logic last);
        op_t op;
        op = '{a: a, b: b, last: last};
        if (n == 0) reqQ0.push_back(op);
        else reqQ1.push_back(op);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!BUSY) break;
        end
        checkFlag(name, BUSY, 1'b0);
    endtask

    task automatic modelReset();
        mPend = 0; mALeft = 0; mBLeft = 0; mL = 0; mLastGrant = 1; mErr = 0;
        mA = '0; mB = '0;
        mTags.delete();
        for (int i = 0; i < 2; i++) begin
            mOutD[i] = '0; mOutL[i] = 1'b0; mOutV[i] = 1'b0;
        end
    endtask

    // Predict every output from the transaction-level state, then advance that state.
    task automatic compareCycle();
        bit gv, gid;
        mtag_t t;
        if (!rstn) modelReset();
        gv  = rstn && !mPend && (mTags.size() < MAXI) && (R0_TVALID || R1_TVALID);
        gid = (R0_TVALID && R1_TVALID) ? !mLastGrant : R1_TVALID;
        checkFlag("R0_TREADY", R0_TREADY, gv && !gid);
        checkFlag("R1_TREADY", R1_TREADY, gv && gid);
        checkFlag("FA_A_TVALID", FA_A_TVALID, mPend && mALeft);
        checkFlag("FA_B_TVALID", FA_B_TVALID, mPend && mBLeft);
        checkOutput("FA_A_TDATA", FA_A_TDATA, mA);
        checkOutput("FA_B_TDATA", FA_B_TDATA, mB);
        checkFlag("FA_A_TLAST", FA_A_TLAST, mL);
        checkFlag("FA_B_TLAST", FA_B_TLAST, mL);
        checkFlag("BUSY", BUSY, mPend || (mTags.size() != 0));
        checkFlag("ERR", ERR, mErr);
        checkFlag("R0_OUT_TVALID", R0_OUT_TVALID, mOutV[0]);
        checkFlag("R1_OUT_TVALID", R1_OUT_TVALID, mOutV[1]);
        checkOutput("R0_OUT_TDATA", R0_OUT_TDATA, mOutD[0]);
        checkOutput("R1_OUT_TDATA", R1_OUT_TDATA, mOutD[1]);
        if (mOutV[0]) checkFlag("R0_OUT_TLAST", R0_OUT_TLAST, mOutL[0]);
        if (mOutV[1]) checkFlag("R1_OUT_TLAST", R1_OUT_TLAST, mOutL[1]);
        if (rstn) begin
            if (R0_TVALID && R0_TREADY) grantLog.push_back(0);
            if (R1_TVALID && R1_TREADY) grantLog.push_back(1);
            if (FA_A_TVALID && FA_A_TREADY) aHs++;
            if (FA_B_TVALID && FA_B_TREADY) bHs++;
            if (R0_OUT_TVALID) begin outCnt0++; rx0.push_back(R0_OUT_TDATA); rxL0.push_back(R0_OUT_TLAST); end
            if (R1_OUT_TVALID) begin outCnt1++; rx1.push_back(R1_OUT_TDATA); rxL1.push_back(R1_OUT_TLAST); end
            mOutV[0] = 1'b0;
            mOutV[1] = 1'b0;
            if (FA_OUT_TVALID) begin
                if (mTags.size() != 0) begin
                    t = mTags.pop_front();
                    mOutV[t.id] = 1'b1; mOutD[t.id] = FA_OUT_TDATA; mOutL[t.id] = t.last;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (mPend) begin
                if (FA_A_TREADY) mALeft = 0;
                if (FA_B_TREADY) mBLeft = 0;
                if (!mALeft && !mBLeft) mPend = 0;
            end
            if (gv) begin
                mPend = 1; mALeft = 1; mBLeft = 1; mLastGrant = gid;
                mA = gid ? R1_A_TDATA : R0_A_TDATA;
                mB = gid ? R1_B_TDATA : R0_B_TDATA;
                mL = gid ? R1_TLAST : R0_TLAST;
                mTags.push_back('{id: gid, last: mL});
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            compareCycle();
        end
    end

    // Requesters hold each queued op on the bus until it is accepted.
    initial begin
        R0_TVALID = 0; R1_TVALID = 0; R0_TLAST = 0; R1_TLAST = 0;
        R0_A_TDATA = '0; R0_B_TDATA = '0; R1_A_TDATA = '0; R1_B_TDATA = '0;
        forever begin
            @(negedge clk);
            h0 = R0_TVALID && R0_TREADY;
            h1 = R1_TVALID && R1_TREADY;
            @(posedge clk);
            #1;
            if (h0 && reqQ0.size() != 0) void'(reqQ0.pop_front());
            if (h1 && reqQ1.size() != 0) void'(reqQ1.pop_front());
            R0_TVALID = (reqQ0.size() != 0);
            R1_TVALID = (reqQ1.size() != 0);
            if (R0_TVALID) {R0_A_TDATA, R0_B_TDATA, R0_TLAST} = reqQ0[0];
            if (R1_TVALID) {R1_A_TDATA, R1_B_TDATA, R1_TLAST} = reqQ1[0];
        end
    end

    // Adder stand-in: forced results first, otherwise integer sums two cycles after issue.
    initial begin
        FA_OUT_TVALID = 0; FA_OUT_TDATA = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                aQ.delete(); bQ.delete(); sumQ.delete();
            end else if (autoEn) begin
                if (FA_A_TVALID && FA_A_TREADY) aQ.push_back(FA_A_TDATA);
                if (FA_B_TVALID && FA_B_TREADY) bQ.push_back(FA_B_TDATA);
                if (aQ.size() != 0 && bQ.size() != 0)
                    sumQ.push_back('{d: int2f(f2int(aQ.pop_front()) + f2int(bQ.pop_front())), due: cyc + 2});
            end
            @(posedge clk);
            #1;
            FA_OUT_TVALID = 0;
            if (manualQ.size() != 0) begin
                FA_OUT_TVALID = 1; FA_OUT_TDATA = manualQ.pop_front();
            end else if (autoEn && sumQ.size() != 0 && sumQ[0].due <= cyc) begin
                FA_OUT_TVALID = 1; FA_OUT_TDATA = sumQ.pop_front().d;
            end
        end
    end

    initial begin
        int g0, o0;
        rstn = 0; FA_A_TREADY = 0; FA_B_TREADY = 0;
        repeat (3) @(negedge clk);
        checkFlag("reset BUSY", BUSY, 1'b0);
        checkFlag("reset ERR", ERR, 1'b0);
        checkFlag("reset FA_A_TVALID", FA_A_TVALID, 1'b0);
        checkOutput("reset R0_OUT_TDATA", R0_OUT_TDATA, 32'h0);
        @(posedge clk); #1;
        rstn = 1; FA_A_TREADY = 1; FA_B_TREADY = 1;

        $display("[TB] single op from R0");
        applyStimulus(0, 32'h3F800000, 32'h40000000, 1'b1);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (FA_A_TVALID) break; end
        checkFlag("single issue valid", FA_A_TVALID, 1'b1);
        checkOutput("single FA_A data", FA_A_TDATA, 32'h3F800000);
        checkOutput("single FA_B data", FA_B_TDATA, 32'h40000000);
        manualQ.push_back(32'h40400000);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (R0_OUT_TVALID) break; end
        checkFlag("single R0 out valid", R0_OUT_TVALID, 1'b1);
        checkOutput("single R0 sum", R0_OUT_TDATA, 32'h40400000);
        checkFlag("single R0 last", R0_OUT_TLAST, 1'b1);
        checkFlag("single R1 quiet", R1_OUT_TVALID, 1'b0);
        @(negedge clk);
        checkFlag("single pulse width", R0_OUT_TVALID, 1'b0);
        checkOutput("single sum held", R0_OUT_TDATA, 32'h40400000);
        waitIdle("single idle");

        $display("[TB] B channel stall");
        FA_B_TREADY = 0;
        g0 = aHs; o0 = bHs;
        applyStimulus(1, 32'h40800000, 32'h3F800000, 1'b1);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (FA_B_TVALID) break; end
        checkFlag("stall B valid", FA_B_TVALID, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("stall A handshakes", 32'(aHs - g0), 32'd1);
        checkFlag("stall A dropped", FA_A_TVALID, 1'b0);
        checkOutput("stall B stable", FA_B_TDATA, 32'h3F800000);
        @(posedge clk); #1 FA_B_TREADY = 1;
        repeat (2) @(negedge clk);
        checkOutput("stall B handshakes", 32'(bHs - o0), 32'd1);
        checkOutput("stall A no duplicate", 32'(aHs - g0), 32'd1);
        o0 = outCnt1;
        manualQ.push_back(32'h40A00000);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (R1_OUT_TVALID) break; end
        checkOutput("stall R1 sum", R1_OUT_TDATA, 32'h40A00000);
        waitIdle("stall idle");
        checkOutput("stall R1 result count", 32'(outCnt1 - o0), 32'd1);

        $display("[TB] interleaved packets");
        autoEn = 1;
        rx0.delete(); rx1.delete(); rxL0.delete(); rxL1.delete();
        g0 = grantLog.size();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, int2f(k), int2f(1), k == 4);
            applyStimulus(1, int2f(k), int2f(2), k == 4);
            exp0.push_back(int2f(k + 1)); expL0.push_back(k == 4);
            exp1.push_back(int2f(k + 2)); expL1.push_back(k == 4);
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx0.size() >= 4 && rx1.size() >= 4) break;
        end
        checkOutput("packet R0 count", 32'(rx0.size()), 32'd4);
        checkOutput("packet R1 count", 32'(rx1.size()), 32'd4);
        if (rx0.size() >= 4 && rx1.size() >= 4 && grantLog.size() >= g0 + 8) begin
            checkOutput("packet R0 first sum", rx0[0], 32'h40000000);
            checkOutput("packet R1 last sum", rx1[3], 32'h40C00000);
            for (int i = 0; i < 4; i++) begin
                checkOutput("packet R0 sum", rx0[i], exp0[i]);
                checkOutput("packet R1 sum", rx1[i], exp1[i]);
                checkFlag("packet R0 tlast", rxL0[i], expL0[i]);
                checkFlag("packet R1 tlast", rxL1[i], expL1[i]);
            end
            for (int i = 0; i < 8; i++)
                checkOutput("packet grant order", 32'(grantLog[g0 + i]), 32'(i % 2));
        end else begin
            checkOutput("packet grant count", 32'(grantLog.size() - g0), 32'd8);
        end
        waitIdle("packet idle");
        autoEn = 0;

        $display("[TB] credit limit");
        g0 = grantLog.size(); o0 = outCnt0;
        for (int i = 0; i < 5; i++) applyStimulus(0, 32'h3F800000, 32'h3F800000, i == 4);
        repeat (20) @(negedge clk);
        checkOutput("credit accepted", 32'(grantLog.size() - g0), 32'd4);
        checkFlag("credit R0 blocked", R0_TREADY, 1'b0);
        checkFlag("credit busy", BUSY, 1'b1);
        manualQ.push_back(32'h11111111);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (grantLog.size() - g0 >= 5) break; end
        checkOutput("credit 5th accepted", 32'(grantLog.size() - g0), 32'd5);
        for (int i = 0; i < 4; i++) manualQ.push_back(32'h22222200 + 32'(i));
        waitIdle("credit idle");
        checkOutput("credit results", 32'(outCnt0 - o0), 32'd5);

        $display("[TB] underflow");
        o0 = outCnt0 + outCnt1;
        manualQ.push_back(32'hDEADBEEF);
        repeat (3) @(negedge clk);
        checkFlag("underflow ERR", ERR, 1'b1);
        repeat (5) @(negedge clk);
        checkFlag("underflow ERR sticky", ERR, 1'b1);
        checkOutput("underflow no output", 32'(outCnt0 + outCnt1 - o0), 32'd0);

        $display("[TB] reset during issue");
        FA_A_TREADY = 0; FA_B_TREADY = 0;
        applyStimulus(0, 32'h40000000, 32'h40000000, 1'b1);
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (FA_A_TVALID) break; end
        checkFlag("reset-issue pending", FA_A_TVALID, 1'b1);
        @(posedge clk); #1;
        rstn = 0;
        reqQ0.delete(); reqQ1.delete();
        #1;
        checkFlag("reset-issue A dropped", FA_A_TVALID, 1'b0);
        checkFlag("reset-issue B dropped", FA_B_TVALID, 1'b0);
        checkFlag("reset-issue BUSY", BUSY, 1'b0);
        checkFlag("reset-issue ERR", ERR, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1; FA_A_TREADY = 1; FA_B_TREADY = 1; autoEn = 1;
        g0 = grantLog.size();
        applyStimulus(1, int2f(3), int2f(3), 1'b1);
        applyStimulus(0, int2f(5), int2f(1), 1'b1);
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (grantLog.size() >= g0 + 2) break; end
        checkOutput("reset-issue grant count", 32'(grantLog.size() - g0), 32'd2);
        if (grantLog.size() >= g0 + 2) begin
            checkOutput("reset-issue first grant", 32'(grantLog[g0]), 32'd0);
            checkOutput("reset-issue second grant", 32'(grantLog[g0 + 1]), 32'd1);
        end
        waitIdle("reset-issue idle");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
